mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit that drives the HI/LO registers of the multicycle MIPS datapath.
//  - Replaces the fixed 32-bit mult/div paths.
//  - The control FSM pulses a start, waits on busy/done, then reads hi/lo through the srcData mux.
//  - Signed by default. Raises a divide-by-zero flag that feeds the exception path.
// PARAMETERS
//  WIDTH   32               operand width; hi/lo are each WIDTH bits
//  CNT_W   $clog2(WIDTH)+1  iteration counter width (derived, do not override)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high reset
//  start_mult   in   1      pulse: begin multiply op_a*op_b
//  start_div    in   1      pulse: begin divide op_a/op_b
//  op_unsigned  in   1      1 = unsigned operation (only with MDU_UNSIGNED_EN, else ignored)
//  op_a         in   WIDTH  multiplicand / dividend (register A)
//  op_b         in   WIDTH  multiplier / divisor (register B)
//  busy         out  1      operation in progress
//  done         out  1      one-cycle pulse: hi/lo updated (or div_zero raised)
//  div_zero     out  1      valid with done: divisor was zero
//  hi           out  WIDTH  mult: upper product half; div: remainder
//  lo           out  WIDTH  mult: lower product half; div: quotient
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset is synchronous and active-high.
//    - Reset clears busy, done, div_zero, hi and lo to 0, and puts the FSM in IDLE.
//    - Reset mid-operation aborts the operation; no done pulse follows.
//  - States: IDLE, MULT, DIV, FIX, DONE.
//  - Start acceptance: start_* is sampled only in IDLE or DONE, on the rising edge of clk.
//    - Start seen in any other state is ignored.
//    - start_mult and start_div together: multiply wins, start_div is dropped.
//  - Operand capture: op_a and op_b are captured at acceptance.
//    - Later input changes do not affect the result.
//  - Signed preparation: operands are converted to magnitudes; result sign and remainder sign are stored.
//  - MULT: shift-add on magnitudes, one bit per cycle, WIDTH cycles, 2*WIDTH accumulator.
//  - DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
//  - FIX (one cycle): applies the signs and writes hi/lo.
//    - Quotient truncates toward zero; remainder takes the dividend's sign.
//    - Overflow case (-2^(WIDTH-1)) / -1: lo = -2^(WIDTH-1), hi = 0 (wraps, no flag).
//  - DONE (one cycle): done = 1, busy = 0. Then IDLE, or a new op if a start is accepted here.
//  - Latency: accept at edge k; busy is high for cycles k+1 .. k+WIDTH+1; done is high in cycle k+WIDTH+2.
//  - Divide by zero: the DIV iteration is skipped (IDLE -> DONE).
//    - done and div_zero are high in cycle k+1; hi/lo keep their old values.
//  - div_zero is 0 whenever done is 0.
//  - hi/lo change only in FIX and on reset; they hold between operations.
// CONFIGURATION
//  MDU_UNSIGNED_EN defined:
//    - op_unsigned = 1 selects unsigned operation (multu/divu).
//    - The magnitude and sign steps are bypassed.
//    - Unsigned results have the same latency as signed ones.
//  MDU_UNSIGNED_EN undefined:
//    - op_unsigned is ignored; all operations are signed.
//    - The port stays present so the control FSM is unchanged.
// STRUCTURE
//  - Package mdu_pkg: state enum (mdu_state_t), op enum (MDU_OP_MULT, MDU_OP_DIV), default WIDTH constant.
//  - Sub-module mdu_sign_fix: combinational conditional-negate/abs, parametrised on WIDTH.
//    - Instanced for operand preparation and for FIX.
//  - All other logic (FSM, counter, accumulator, shifter) lives in mult_div_unit.
// TESTING
//  - Multiply, signed: mult a=-3, b=7 -> done at k+34, hi=FFFFFFFF, lo=FFFFFFEB, div_zero=0.
//  - Divide, signed: div a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); busy high for 33 cycles.
//  - Divide by zero: div a=5, b=0 -> done and div_zero high at k+1; hi/lo unchanged from the previous op.
//  - Overflow and unsigned:
//    - div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
//    - With MDU_UNSIGNED_EN, op_unsigned=1, mult FFFFFFFF*2 -> hi=1, lo=FFFFFFFE.
//  - Start while busy: start_div pulsed at k+5 during a mult -> ignored; exactly one done, mult result intact.
//  - Simultaneous starts: start_mult and start_div together -> multiply result.
//  - Reset mid-op: reset at k+10 -> busy=0, hi=lo=0 next cycle; no done pulse afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_t;

    typedef enum logic {
        MDU_OP_MULT,
        MDU_OP_DIV
    } mdu_op_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational conditional negate: abs() on operands, sign restore on results.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign value_o = negate_i ? ((~value_i) + ONE) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider feeding HI/LO.
// Optional macro MDU_UNSIGNED_EN enables op_unsigned (multu/divu).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             op_unsigned,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic signed_op;
`ifdef MDU_UNSIGNED_EN
    assign signed_op = ~op_unsigned;
`else
    logic unused_op_unsigned;
    assign signed_op          = 1'b1;
    assign unused_op_unsigned = op_unsigned;
`endif

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .value_i(op_a), .negate_i(signed_op & op_a[WIDTH-1]), .value_o(a_mag));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .value_i(op_b), .negate_i(signed_op & op_b[WIDTH-1]), .value_o(b_mag));
    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value_i(acc_q), .negate_i(neg_res_q), .value_o(prod_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
        .value_i(acc_q[WIDTH-1:0]), .negate_i(neg_res_q), .value_o(quot_fixed));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value_i(acc_q[2*WIDTH-1:WIDTH]), .negate_i(neg_rem_q), .value_o(rem_fixed));

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               q_bit;
    logic [2*WIDTH-1:0] mult_next, div_next;

    always_comb begin
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mult_next = {add_sum, acc_q[WIDTH-1:1]};
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        q_bit     = ~rem_diff[WIDTH];
        div_next  = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_mult || start_div) begin
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    b_d       = b_mag;
                    cnt_d     = '0;
                    dz_d      = 1'b0;
                    neg_res_d = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    neg_rem_d = signed_op & op_a[WIDTH-1];
                    if (start_mult) begin
                        op_d    = MDU_OP_MULT;
                        state_d = S_MULT;
                    end else begin
                        op_d = MDU_OP_DIV;
                        // A zero divisor skips the iteration entirely
                        if (op_b == '0) begin
                            dz_d    = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                end
            end
            S_MULT: begin
                acc_d = mult_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q == MDU_OP_MULT) begin
                    {hi_d, lo_d} = prod_fixed;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= MDU_OP_MULT;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = done & dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam int EXP_LAT  = W + 2;
    localparam int EXP_BUSY = W + 1;

    logic         clk = 1'b0;
    logic         reset, start_mult, start_div, op_unsigned;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int passed = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .op_unsigned(op_unsigned), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned HI/LO from plain SV arithmetic
    function automatic void model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit uns, output logic [W-1:0] h, output logic [W-1:0] l);
        bit s;
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0] up;
        logic signed [W-1:0] sa, sb;
`ifdef MDU_UNSIGNED_EN
        s = !uns;
`else
        s = 1'b1;
        if (uns) s = 1'b1;
`endif
        sa = a;
        sb = b;
        if (is_mult) begin
            if (s) begin
                sp = 64'(sa) * 64'(sb);
                {h, l} = sp;
            end else begin
                up = {32'b0, a} * {32'b0, b};
                {h, l} = up;
            end
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = 32'h8000_0000;
                h = 32'h0;
            end else begin
                l = sa / sb;
                h = sa % sb;
            end
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    // Driver: issue one op, then wait (bounded) for done and report observations
    task automatic do_op(input bit sm, input bit sd, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit uns, output int lat, output int bcnt, output int stray,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        op_a = a; op_b = b; op_unsigned = uns;
        start_mult = sm; start_div = sd;
        tick();
        start_mult = 1'b0; start_div = 1'b0;
        op_a = $urandom; op_b = $urandom; op_unsigned = 1'($urandom_range(0, 1));
        lat = 1; bcnt = 0; stray = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (div_zero) stray++;
            tick();
            lat++;
        end
        h = hi; l = lo; dz = div_zero;
    endtask

    task automatic test_reset;
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; op_unsigned = 1'b0;
        op_a = '0; op_b = '0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        checks++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero got=%b exp=0", div_zero); else passed++;
        checks++; if (hi !== '0) $display("FAIL reset_hi got=%h exp=0", hi); else passed++;
        checks++; if (lo !== '0) $display("FAIL reset_lo got=%h exp=0", lo); else passed++;
        reset = 1'b0;
        tick();
    endtask

    // Runs one op (non-zero divisor) and checks latency, busy length, flags and results
    task automatic run_and_check(input string name, input bit sm, input bit sd,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input bit uns);
        int lat, bcnt, stray;
        logic [W-1:0] h, l, eh, el;
        logic dz;
        model(sm, a, b, uns, eh, el);
        do_op(sm, sd, a, b, uns, lat, bcnt, stray, h, l, dz);
        checks++;
        if (lat !== EXP_LAT || bcnt !== EXP_BUSY || stray !== 0)
            $display("FAIL %s_timing a=%h b=%h got lat=%0d busy=%0d dzlow=%0d exp lat=%0d busy=%0d dzlow=0",
                     name, a, b, lat, bcnt, stray, EXP_LAT, EXP_BUSY);
        else passed++;
        checks++;
        if (h !== eh || l !== el || dz !== 1'b0)
            $display("FAIL %s_result a=%h b=%h u=%0d got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=0",
                     name, a, b, uns, h, l, dz, eh, el);
        else passed++;
        last_hi = eh; last_lo = el;
    endtask

    task automatic test_mult_signed;
        run_and_check("mult_dir", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB)
            $display("FAIL mult_m3x7 got hi=%h lo=%h exp hi=ffffffff lo=ffffffeb", hi, lo);
        else passed++;
        for (int i = 0; i < 6; i++)
            run_and_check("mult_rand", 1'b1, 1'b0, $urandom, $urandom, 1'b0);
        run_and_check("mult_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_div_signed;
        logic [W-1:0] b;
        run_and_check("div_dir", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
            $display("FAIL div_m7d2 got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            b = $urandom;
            if (i % 2 == 1) b = W'($urandom_range(1, 300)) ^ {W{b[W-1]}};
            if (b == '0) b = 32'd3;
            run_and_check("div_rand", 1'b0, 1'b1, $urandom, b, 1'b0);
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt, stray;
        logic [W-1:0] h, l;
        logic dz;
        do_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, lat, bcnt, stray, h, l, dz);
        checks++;
        if (lat !== 1 || bcnt !== 0 || dz !== 1'b1 || done !== 1'b1)
            $display("FAIL divzero_flag got lat=%0d busy=%0d dz=%b exp lat=1 busy=0 dz=1", lat, bcnt, dz);
        else passed++;
        checks++;
        if (h !== last_hi || l !== last_lo)
            $display("FAIL divzero_hold got hi=%h lo=%h exp hi=%h lo=%h", h, l, last_hi, last_lo);
        else passed++;
        tick();
        checks++;
        if (done !== 1'b0 || div_zero !== 1'b0)
            $display("FAIL divzero_clear got done=%b dz=%b exp 0 0", done, div_zero);
        else passed++;
    endtask

    task automatic test_overflow;
        run_and_check("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000)
            $display("FAIL div_ovf_val got hi=%h lo=%h exp hi=0 lo=80000000", hi, lo);
        else passed++;
    endtask

    task automatic test_unsigned;
        logic [W-1:0] b;
        run_and_check("multu", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            b = $urandom;
            if (b == '0) b = 32'd9;
            run_and_check("divu", 1'b0, 1'b1, $urandom | 32'h8000_0000, b, 1'b1);
        end
    endtask

    task automatic test_start_while_busy;
        logic [W-1:0] a, b, eh, el, h, l;
        int c, ndone, first;
        a = $urandom; b = $urandom;
        model(1'b1, a, b, 1'b0, eh, el);
        op_a = a; op_b = b; op_unsigned = 1'b0; start_mult = 1'b1;
        tick(); c = 1;
        start_mult = 1'b0;
        repeat (3) begin tick(); c++; end
        start_div = 1'b1; op_a = $urandom; op_b = 32'd1;
        tick(); c++;
        start_div = 1'b0;
        ndone = 0; first = -1; h = '0; l = '0;
        while (c < 80) begin
            if (done) begin
                ndone++;
                if (first < 0) begin first = c; h = hi; l = lo; end
            end
            tick(); c++;
        end
        checks++;
        if (ndone !== 1 || first !== EXP_LAT)
            $display("FAIL busy_start_done got count=%0d at=%0d exp count=1 at=%0d", ndone, first, EXP_LAT);
        else passed++;
        checks++;
        if (h !== eh || l !== el)
            $display("FAIL busy_start_result got hi=%h lo=%h exp hi=%h lo=%h", h, l, eh, el);
        else passed++;
        last_hi = eh; last_lo = el;
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 2; i++)
            run_and_check("both_starts", 1'b1, 1'b1, $urandom, $urandom | 32'd1, 1'b0);
    endtask

    task automatic test_back_to_back;
        int lat, bcnt, stray;
        logic [W-1:0] a, b, h, l, eh, el;
        logic dz;
        bit m, u;
        for (int i = 0; i < 8; i++) begin
            m = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            if (m || b != '0) model(m, a, b, u, eh, el);
            else begin eh = last_hi; el = last_lo; end
            do_op(m, !m, a, b, u, lat, bcnt, stray, h, l, dz);
            checks++;
            if (!m && b == '0) begin
                if (lat !== 1 || dz !== 1'b1 || h !== eh || l !== el)
                    $display("FAIL b2b_divzero got lat=%0d dz=%b hi=%h lo=%h exp lat=1 dz=1 hi=%h lo=%h",
                             lat, dz, h, l, eh, el);
                else passed++;
            end else begin
                if (lat !== EXP_LAT || dz !== 1'b0 || stray !== 0 || h !== eh || l !== el)
                    $display("FAIL b2b_op m=%0d a=%h b=%h u=%0d got lat=%0d dz=%b hi=%h lo=%h exp lat=%0d dz=0 hi=%h lo=%h",
                             m, a, b, u, lat, dz, h, l, EXP_LAT, eh, el);
                else passed++;
            end
            last_hi = eh; last_lo = el;
        end
    endtask

    task automatic test_reset_mid;
        int c, ndone;
        op_a = $urandom | 32'd1; op_b = $urandom | 32'd1; start_mult = 1'b1;
        tick(); c = 1;
        start_mult = 1'b0;
        while (c < 9) begin tick(); c++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0)
            $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h exp 0 0 0 0", busy, done, hi, lo);
        else passed++;
        ndone = 0;
        repeat (60) begin
            if (done) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 0) $display("FAIL reset_mid_no_done got=%0d exp=0", ndone); else passed++;
        last_hi = '0; last_lo = '0;
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_unsigned();
        test_start_while_busy();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_div_zero();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
